// File: rtl/decoder_nto2n_scan.sv
// Registered N-to-2^N one-hot (or one-cold) decoder.
// Direct mode decodes a handshaked index; scan mode steps through every line on a prescaled tick.
module decoder_nto2n_scan #(
  parameter int unsigned N          = 2,
  parameter int unsigned PRESCALE   = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      i,
  input  logic              in_valid,
  output logic [2**N-1:0]   d,
  output logic [N-1:0]      idx,
  output logic              out_valid
);

  localparam int unsigned W  = 2**N;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PW-1:0] PC_LAST = PW'(PRESCALE - 1);
  localparam logic [W-1:0]  D_RST   = {W{ACTIVE_LOW}};

  logic [PW-1:0] pc_q, pc_d;
  logic [N-1:0]  idx_q, idx_d;
  logic [W-1:0]  d_q, d_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  idx_next;

  // Selected line in the configured polarity.
  function automatic logic [W-1:0] decode(input logic [N-1:0] x);
    logic [W-1:0] v;
    v    = '0;
    v[x] = 1'b1;
    return ACTIVE_LOW ? ~v : v;
  endfunction

  // Scan increment wraps naturally at N bits.
  assign idx_next = idx_q + N'(1);

  // Next-state: direct mode holds pc at zero, which also clears it on any mode change.
  always_comb begin
    pc_d        = pc_q;
    idx_d       = idx_q;
    d_d         = d_q;
    out_valid_d = 1'b0;
    if (en) begin
      if (!mode) begin
        pc_d = '0;
        if (in_valid) begin
          idx_d       = i;
          d_d         = decode(i);
          out_valid_d = 1'b1;
        end
      end else if (pc_q == PC_LAST) begin
        pc_d        = '0;
        idx_d       = idx_next;
        d_d         = decode(idx_next);
        out_valid_d = 1'b1;
      end else begin
        pc_d = pc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= '0;
      idx_q       <= '0;
      d_q         <= D_RST;
      out_valid_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      idx_q       <= idx_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign d         = d_q;
  assign idx       = idx_q;
  assign out_valid = out_valid_q;

endmodule
